regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 4x8 register file between two requesters.
  - Requester 0: core writeback.
  - Requester 1: loader/debug path.
- Uses a valid/ready handshake, with round-robin or fixed-priority arbitration.
- Contains a clear sequencer that sweeps R0..R3 to a constant on command.
- Sits between the requesters and the register file's write, dr and wrData inputs; its outputs are registered.

Parameters:
- PRIORITY_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with requester 0 highest.
- CLR_VALUE, 8'h00, value written to every register during a clear sweep.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_dr  in  2  requester 0 destination register.
- req0_data  in  8  requester 0 write data.
- req0_ready  out  1  requester 0 accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has a write pending.
- req1_dr  in  2  requester 1 destination register.
- req1_data  in  8  requester 1 write data.
- req1_ready  out  1  requester 1 accepted this cycle (combinational).
- clr_start  in  1  single-cycle pulse requesting a clear sweep.
- busy  out  1  clear sweep in progress.
- write  out  1  register file write enable (registered).
- dr  out  2  register file write address (registered).
- wrData  out  8  register file write data (registered).
- cnt0  out  8  grant count for requester 0 (optional feature).
- cnt1  out  8  grant count for requester 1 (optional feature).

Behaviour:
- Reset (asynchronous): state IDLE; write=0, dr=0, wrData=0, busy=0, cnt0=cnt1=0; last_grant=1, so requester 0 is favoured first.
- States: IDLE and CLEAR. busy = (state==CLEAR).
- Arbitration is combinational and runs only when state==IDLE and clr_start==0; otherwise both ready outputs are 0.
  - Only one valid requester: it is granted.
  - Both valid, PRIORITY_MODE=0: grant the requester not equal to last_grant.
  - Both valid, PRIORITY_MODE=1: always grant requester 0.
  - At most one ready is high per cycle. ready never depends on ready.
- Transfer happens when reqN_valid & reqN_ready at a rising edge.
  - Next cycle: write=1, dr=reqN_dr, wrData=reqN_data; last_grant=N.
  - Latency: accept at edge k, register file captures at edge k+1.
- No transfer and not clearing: write=0; dr and wrData hold their previous values.
- Requesters must hold valid, dr and data stable until ready. The arbiter does not buffer.
- Two requesters targeting the same dr are serialised in grant order. The last granted write wins. No merging or dropping.
- clr_start in IDLE:
  - In that same cycle no request is accepted.
  - Next state is CLEAR with sweep index i=0.
- CLEAR:
  - Each cycle outputs write=1, dr=i, wrData=CLR_VALUE, then i increments.
  - After i=3 is issued, return to IDLE.
  - The sweep therefore occupies exactly 4 consecutive write cycles and busy is high for exactly those 4 cycles.
  - Arbitration resumes in the cycle after the last clear write.
- clr_start during CLEAR is ignored. It does not restart or extend the sweep.
- The sweep index wraps 3 -> done. It never writes an index a second time.
- Reset asserted mid-sweep aborts the sweep immediately: IDLE, write=0. Any partially cleared registers are left as written.
- last_grant is unchanged by a clear sweep.

Optional Feature:
- Macro: ARB_CNT_EN.
- Defined:
  - cnt0 and cnt1 increment by 1 on each accepted transfer of their requester.
  - They saturate at 8'hFF and do not count clear writes.
  - Cleared only by reset.
- Undefined: cnt0 and cnt1 are tied to 8'h00 and no counter flops are inferred.

Test Plan:
- Reset then idle: write=0, dr=0, wrData=0, busy=0, both ready=0 with no valid inputs.
- req0 only, dr=2, data=8'hA5: req0_ready=1 for one cycle; next cycle write=1, dr=2, wrData=8'hA5; following cycle write=0.
- Both valid for 4 cycles, PRIORITY_MODE=0, req0 dr=1/8'h11, req1 dr=3/8'h33: grants ordered 0,1,0,1; write sequence alternates dr=1 and dr=3.
- Both valid, PRIORITY_MODE=1: req0 granted every cycle and req1_ready stays 0 until req0_valid drops.
- clr_start with req1 valid, CLR_VALUE=8'h00: req1_ready=0 for 5 cycles (the clr_start cycle plus 4 busy cycles); writes dr=0,1,2,3 with 8'h00; busy high 4 cycles; a second clr_start in the 2nd busy cycle causes no extra writes; req1 is granted in the cycle after the sweep.
- ARB_CNT_EN defined, 300 req1 grants: cnt1=8'hFF, cnt0=0. Reset asserted mid-sweep after 2 writes: write=0 and busy=0 immediately, and no further clear writes.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 4x8 register file: two valid/ready requesters plus a clear sweep.
// Define ARB_CNT_EN to add saturating per-requester grant counters on cnt0/cnt1.
module regfile_write_arbiter #(
    parameter int         PRIORITY_MODE = 0,
    parameter logic [7:0] CLR_VALUE     = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [1:0] req0_dr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_dr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       clr_start,
    output logic       busy,
    output logic       write,
    output logic [1:0] dr,
    output logic [7:0] wrData,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0] state;
    logic [1:0] sweep_idx;
    logic       last_grant;
    logic       arb_en;
    logic       grant0;
    logic       grant1;

    // Requester 0 wins a tie in fixed-priority mode, or in round-robin when requester 1 went last.
    always_comb begin
        arb_en = (state == IDLE) && !clr_start;
        grant0 = arb_en && req0_valid &&
                 (!req1_valid || (PRIORITY_MODE != 0) || last_grant);
        grant1 = arb_en && req1_valid && !grant0;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state == CLEAR);

    // The first clear write is issued on the edge that enters CLEAR, so busy and write coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sweep_idx  <= 2'd0;
            last_grant <= 1'b1;
            write      <= 1'b0;
            dr         <= 2'd0;
            wrData     <= 8'h00;
        end else if (state == IDLE) begin
            if (clr_start) begin
                state     <= CLEAR;
                sweep_idx <= 2'd0;
                write     <= 1'b1;
                dr        <= 2'd0;
                wrData    <= CLR_VALUE;
            end else if (grant0) begin
                write      <= 1'b1;
                dr         <= req0_dr;
                wrData     <= req0_data;
                last_grant <= 1'b0;
            end else if (grant1) begin
                write      <= 1'b1;
                dr         <= req1_dr;
                wrData     <= req1_data;
                last_grant <= 1'b1;
            end else begin
                write <= 1'b0;
            end
        end else begin
            if (sweep_idx == 2'd3) begin
                state <= IDLE;
                write <= 1'b0;
            end else begin
                sweep_idx <= sweep_idx + 2'd1;
                write     <= 1'b1;
                dr        <= sweep_idx + 2'd1;
                wrData    <= CLR_VALUE;
            end
        end
    end

`ifdef ARB_CNT_EN
    logic [7:0] cnt0_q;
    logic [7:0] cnt1_q;

    // Counters track accepted requester transfers only and stick at 8'hFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= 8'h00;
            cnt1_q <= 8'h00;
        end else begin
            if (grant0 && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
            if (grant1 && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = 8'h00;
    assign cnt1 = 8'h00;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a round-robin instance and a fixed-priority instance.
// Counter expectations follow whether ARB_CNT_EN is defined for the build.
module tb_regfile_write_arbiter;

`ifdef ARB_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] dr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic       v0;
        logic [1:0] dr0;
        logic [7:0] d0;
        logic       v1;
        logic [1:0] dr1;
        logic [7:0] d1;
        logic       clr;
        logic       r0;
        logic       r1;
        logic       bsy;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   misses = 0;

    logic       a_v0 = 0, a_v1 = 0, a_clr = 0;
    logic [1:0] a_dr0 = 0, a_dr1 = 0;
    logic [7:0] a_d0 = 0, a_d1 = 0;
    logic       a_r0, a_r1, a_busy, a_write;
    logic [1:0] a_dr;
    logic [7:0] a_data, a_cnt0, a_cnt1;

    logic       p_v0 = 0, p_v1 = 0, p_clr = 0;
    logic [1:0] p_dr0 = 0, p_dr1 = 0;
    logic [7:0] p_d0 = 0, p_d1 = 0;
    logic       p_r0, p_r1, p_busy, p_write;
    logic [1:0] p_dr;
    logic [7:0] p_data, p_cnt0, p_cnt1;

    wr_t        qa[$];
    wr_t        qp[$];
    wr_t        ea, ep;
    logic [1:0] last_dr_a = 0, last_dr_p = 0;
    logic [7:0] last_data_a = 0, last_data_p = 0;

    regfile_write_arbiter #(.PRIORITY_MODE(0), .CLR_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(a_v0), .req0_dr(a_dr0), .req0_data(a_d0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_dr(a_dr1), .req1_data(a_d1), .req1_ready(a_r1),
        .clr_start(a_clr), .busy(a_busy), .write(a_write), .dr(a_dr), .wrData(a_data),
        .cnt0(a_cnt0), .cnt1(a_cnt1)
    );

    regfile_write_arbiter #(.PRIORITY_MODE(1), .CLR_VALUE(8'h5A)) dut_p (
        .clk(clk), .reset(reset),
        .req0_valid(p_v0), .req0_dr(p_dr0), .req0_data(p_d0), .req0_ready(p_r0),
        .req1_valid(p_v1), .req1_dr(p_dr1), .req1_data(p_d1), .req1_ready(p_r1),
        .clr_start(p_clr), .busy(p_busy), .write(p_write), .dr(p_dr), .wrData(p_data),
        .cnt0(p_cnt0), .cnt1(p_cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [1:0] dr0, input logic [7:0] d0,
                                input logic v1, input logic [1:0] dr1, input logic [7:0] d1,
                                input logic clr, input logic r0, input logic r1, input logic bsy);
        vec_t v;
        v.v0 = v0; v.dr0 = dr0; v.d0 = d0;
        v.v1 = v1; v.dr1 = dr1; v.d1 = d1;
        v.clr = clr; v.r0 = r0; v.r1 = r1; v.bsy = bsy;
        return v;
    endfunction

    // One cycle: drive after the edge, check ready/busy mid-cycle, and queue the write expected next cycle.
    task automatic applyStimulus(input bit sel, input vec_t v);
        @(posedge clk);
        #1;
        if (!sel) begin
            a_v0 = v.v0; a_dr0 = v.dr0; a_d0 = v.d0;
            a_v1 = v.v1; a_dr1 = v.dr1; a_d1 = v.d1; a_clr = v.clr;
        end else begin
            p_v0 = v.v0; p_dr0 = v.dr0; p_d0 = v.d0;
            p_v1 = v.v1; p_dr1 = v.dr1; p_d1 = v.d1; p_clr = v.clr;
        end
        @(negedge clk);
        if (!sel) begin
            checkOutput("A.req0_ready", 32'(a_r0), 32'(v.r0));
            checkOutput("A.req1_ready", 32'(a_r1), 32'(v.r1));
            checkOutput("A.busy", 32'(a_busy), 32'(v.bsy));
            if (v.r0) qa.push_back(wr_t'{cyc: cyc + 1, dr: v.dr0, data: v.d0});
            if (v.r1) qa.push_back(wr_t'{cyc: cyc + 1, dr: v.dr1, data: v.d1});
        end else begin
            checkOutput("P.req0_ready", 32'(p_r0), 32'(v.r0));
            checkOutput("P.req1_ready", 32'(p_r1), 32'(v.r1));
            checkOutput("P.busy", 32'(p_busy), 32'(v.bsy));
            if (v.r0) qp.push_back(wr_t'{cyc: cyc + 1, dr: v.dr0, data: v.d0});
            if (v.r1) qp.push_back(wr_t'{cyc: cyc + 1, dr: v.dr1, data: v.d1});
        end
    endtask

    task automatic pushClear(input bit sel, input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) begin
            if (!sel) qa.push_back(wr_t'{cyc: cyc + 1 + i, dr: 2'(i), data: val});
            else      qp.push_back(wr_t'{cyc: cyc + 1 + i, dr: 2'(i), data: val});
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        a_v0 = 0; a_v1 = 0; a_clr = 0;
        p_v0 = 0; p_v1 = 0; p_clr = 0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor for the round-robin instance: pops an entry when its cycle arrives, else expects held outputs.
    always @(negedge clk) begin
        if (reset) begin
            last_dr_a   = 2'd0;
            last_data_a = 8'h00;
            checkOutput("A.reset_write", 32'(a_write), 32'd0);
        end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
            ea = qa.pop_front();
            checkOutput("A.write_cycle", 32'(cyc), 32'(ea.cyc));
            checkOutput("A.write", 32'(a_write), 32'd1);
            checkOutput("A.dr", 32'(a_dr), 32'(ea.dr));
            checkOutput("A.wrData", 32'(a_data), 32'(ea.data));
            last_dr_a   = ea.dr;
            last_data_a = ea.data;
        end else begin
            checkOutput("A.idle_write", 32'(a_write), 32'd0);
            checkOutput("A.hold_dr", 32'(a_dr), 32'(last_dr_a));
            checkOutput("A.hold_wrData", 32'(a_data), 32'(last_data_a));
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            last_dr_p   = 2'd0;
            last_data_p = 8'h00;
            checkOutput("P.reset_write", 32'(p_write), 32'd0);
        end else if (qp.size() != 0 && qp[0].cyc <= cyc) begin
            ep = qp.pop_front();
            checkOutput("P.write_cycle", 32'(cyc), 32'(ep.cyc));
            checkOutput("P.write", 32'(p_write), 32'd1);
            checkOutput("P.dr", 32'(p_dr), 32'(ep.dr));
            checkOutput("P.wrData", 32'(p_data), 32'(ep.data));
            last_dr_p   = ep.dr;
            last_data_p = ep.data;
        end else begin
            checkOutput("P.idle_write", 32'(p_write), 32'd0);
            checkOutput("P.hold_dr", 32'(p_dr), 32'(last_dr_p));
            checkOutput("P.hold_wrData", 32'(p_data), 32'(last_data_p));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("A.rst_write", 32'(a_write), 32'd0);
        checkOutput("A.rst_dr", 32'(a_dr), 32'd0);
        checkOutput("A.rst_wrData", 32'(a_data), 32'd0);
        checkOutput("A.rst_busy", 32'(a_busy), 32'd0);
        checkOutput("A.rst_ready0", 32'(a_r0), 32'd0);
        checkOutput("A.rst_ready1", 32'(a_r1), 32'd0);
        checkOutput("A.rst_cnt0", 32'(a_cnt0), 32'd0);
        checkOutput("A.rst_cnt1", 32'(a_cnt1), 32'd0);

        applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));

        // Round-robin from reset: requester 0 first, then alternating.
        for (int i = 0; i < 4; i++)
            applyStimulus(0, mk(1, 2'd1, 8'h11, 1, 2'd3, 8'h33, 0, (i % 2) == 0, (i % 2) == 1, 0));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));

        applyStimulus(0, mk(1, 2'd2, 8'hA5, 0, 2'd0, 8'h00, 0, 1, 0, 0));
        applyStimulus(0, mk(0, 2'd2, 8'hA5, 0, 2'd0, 8'h00, 0, 0, 0, 0));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));

        // Clear with requester 1 waiting; a second clr_start lands in the 2nd busy cycle.
        applyStimulus(0, mk(0, 2'd0, 8'h00, 1, 2'd2, 8'h77, 1, 0, 0, 0));
        pushClear(0, 4, 8'h00);
        applyStimulus(0, mk(0, 2'd0, 8'h00, 1, 2'd2, 8'h77, 0, 0, 0, 1));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 1, 2'd2, 8'h77, 1, 0, 0, 1));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 1, 2'd2, 8'h77, 0, 0, 0, 1));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 1, 2'd2, 8'h77, 0, 0, 0, 1));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 1, 2'd2, 8'h77, 0, 0, 1, 0));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));

        // Same destination from both sides: serialised, requester 1's value lands last.
        applyStimulus(0, mk(1, 2'd2, 8'hC1, 1, 2'd2, 8'hC2, 0, 1, 0, 0));
        applyStimulus(0, mk(0, 2'd2, 8'hC1, 1, 2'd2, 8'hC2, 0, 0, 1, 0));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));

        // A sweep must not disturb last_grant: requester 0 is still next after it.
        applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 0, 0, 0));
        pushClear(0, 4, 8'h00);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 1));
        applyStimulus(0, mk(1, 2'd0, 8'h9C, 1, 2'd1, 8'h6D, 0, 1, 0, 0));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));
        checkOutput("A.cnt0_mid", 32'(a_cnt0), CNT_EN ? 32'd5 : 32'd0);
        checkOutput("A.cnt1_mid", 32'(a_cnt1), CNT_EN ? 32'd4 : 32'd0);

        // Fixed-priority instance: requester 1 waits until requester 0 drops.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, mk(1, 2'd0, 8'h0F, 1, 2'd1, 8'hF0, 0, 1, 0, 0));
        applyStimulus(1, mk(0, 2'd0, 8'h00, 1, 2'd1, 8'hF0, 0, 0, 1, 0));
        applyStimulus(1, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));
        applyStimulus(1, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 0, 0, 0));
        pushClear(1, 4, 8'h5A);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 1));
        applyStimulus(1, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));
        checkOutput("P.cnt0", 32'(p_cnt0), CNT_EN ? 32'd3 : 32'd0);
        checkOutput("P.cnt1", 32'(p_cnt1), CNT_EN ? 32'd1 : 32'd0);

        doReset();
        for (int i = 0; i < 300; i++)
            applyStimulus(0, mk(0, 2'd0, 8'h00, 1, 2'(i), 8'(i), 0, 0, 1, 0));
        applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));
        checkOutput("A.cnt1_sat", 32'(a_cnt1), CNT_EN ? 32'hFF : 32'd0);
        checkOutput("A.cnt0_zero", 32'(a_cnt0), 32'd0);

        // Reset two writes into a sweep: outputs drop at once and nothing further is written.
        applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 0, 0, 0));
        pushClear(0, 2, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        a_clr = 1'b0;
        #1;
        checkOutput("A.abort_write", 32'(a_write), 32'd0);
        checkOutput("A.abort_busy", 32'(a_busy), 32'd0);
        checkOutput("A.abort_dr", 32'(a_dr), 32'd0);
        checkOutput("A.abort_cnt1", 32'(a_cnt1), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(0, mk(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 0, 0));

        checkOutput("A.pending", 32'(qa.size()), 32'd0);
        checkOutput("P.pending", 32'(qp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
